// File: rtl/loader_pkg.sv
// Shared definitions for the memory bus loader: command codes, default
// response bytes and the frame FSM state encoding.
package loader_pkg;

    localparam logic [7:0] CMD_WRITE   = 8'h57;
    localparam logic [7:0] CMD_READ    = 8'h52;
    localparam logic [7:0] ACK_DEFAULT = 8'h06;
    localparam logic [7:0] NAK_DEFAULT = 8'h15;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE = 3'd0;
    localparam state_t S_ADDR = 3'd1;
    localparam state_t S_DATA = 3'd2;
    localparam state_t S_BUS  = 3'd3;
    localparam state_t S_RESP = 3'd4;

    // The bus is word-addressed; the frame's low address bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/loader_resp_ser.sv
// Response serializer: emits 1 or 4 bytes of a word LSB-first on a
// valid/ready byte channel and pulses o_done on the last transfer.
module loader_resp_ser
    import loader_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [31:0] i_word,
    input  logic        i_four,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_done
);

    logic [7:0]  r_data;
    logic [23:0] r_rest;
    logic [1:0]  r_left;
    logic        r_valid;
    logic        w_xfer;

    assign w_xfer     = r_valid & i_tx_ready;
    assign o_done     = w_xfer & (r_left == 2'd0);
    assign o_tx_data  = r_data;
    assign o_tx_valid = r_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data  <= '0;
            r_rest  <= '0;
            r_left  <= '0;
            r_valid <= 1'b0;
        end else if (i_start) begin
            r_valid <= 1'b1;
            r_data  <= i_word[7:0];
            r_rest  <= i_word[31:8];
            r_left  <= i_four ? 2'd3 : 2'd0;
        end else if (w_xfer) begin
            if (r_left == 2'd0) begin
                r_valid <= 1'b0;
            end else begin
                r_data <= r_rest[7:0];
                r_rest <= {8'h00, r_rest[23:8]};
                r_left <= r_left - 2'd1;
            end
        end
    end

endmodule

// File: rtl/mem_bus_loader.sv
// Byte-stream driven bus initiator: decodes 'W'/'R' host frames into single
// word bus accesses and answers with read data, ACK or NAK.
module mem_bus_loader
    import loader_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 1024,
    parameter logic [7:0]  ACK_BYTE = ACK_DEFAULT,
    parameter logic [7:0]  NAK_BYTE = NAK_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        active
);

    localparam int unsigned   TW       = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t        r_state;
    logic [1:0]    r_byte_cnt;
    logic          r_is_write;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [TW-1:0] r_tmo;

    logic          w_rx_fire;
    logic          w_is_cmd;
    logic          w_tmo_hit;
    logic          w_bus_ok;
    logic          w_bus_fail;
    logic          w_bad_cmd;
    logic          w_start;
    logic          w_four;
    logic [31:0]   w_word;
    logic          w_done;

    assign rx_ready  = (r_state == S_IDLE) || (r_state == S_ADDR) || (r_state == S_DATA);
    assign w_rx_fire = rx_valid & rx_ready;
    assign w_is_cmd  = (rx_data == CMD_WRITE) || (rx_data == CMD_READ);

    // mem_ready takes priority, so a completion in the expiring cycle succeeds.
    assign w_tmo_hit  = (TIMEOUT != 0) && (r_tmo == TMO_LAST);
    assign w_bus_ok   = (r_state == S_BUS) && mem_ready;
    assign w_bus_fail = (r_state == S_BUS) && !mem_ready && w_tmo_hit;
    assign w_bad_cmd  = (r_state == S_IDLE) && w_rx_fire && !w_is_cmd;

    assign w_start = w_bus_ok | w_bus_fail | w_bad_cmd;
    assign w_four  = w_bus_ok & ~r_is_write;
    assign w_word  = w_four ? mem_rdata : {24'h000000, (w_bus_ok ? ACK_BYTE : NAK_BYTE)};

    assign mem_valid = (r_state == S_BUS);
    assign mem_addr  = word_align(r_addr);
    assign mem_wdata = r_wdata;
    assign mem_wstrb = ((r_state == S_BUS) && r_is_write) ? 4'hF : 4'h0;
    assign active    = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_byte_cnt <= '0;
            r_is_write <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_tmo      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_rx_fire) begin
                        if (w_is_cmd) begin
                            r_state    <= S_ADDR;
                            r_byte_cnt <= '0;
                            r_is_write <= (rx_data == CMD_WRITE);
                        end else begin
                            r_state <= S_RESP;
                        end
                    end
                end
                S_ADDR: begin
                    if (w_rx_fire) begin
                        r_addr[{r_byte_cnt, 3'b000} +: 8] <= rx_data;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_state <= r_is_write ? S_DATA : S_BUS;
                            r_tmo   <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (w_rx_fire) begin
                        r_wdata[{r_byte_cnt, 3'b000} +: 8] <= rx_data;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_state <= S_BUS;
                            r_tmo   <= '0;
                        end
                    end
                end
                S_BUS: begin
                    if (w_bus_ok || w_bus_fail) begin
                        r_state <= S_RESP;
                    end else if (r_tmo != '1) begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_RESP: begin
                    if (w_done) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    loader_resp_ser u_resp_ser (
        .i_clk      (clk),
        .i_rst_n    (resetn),
        .i_start    (w_start),
        .i_word     (w_word),
        .i_four     (w_four),
        .o_tx_data  (tx_data),
        .o_tx_valid (tx_valid),
        .i_tx_ready (tx_ready),
        .o_done     (w_done)
    );

endmodule

// File: tb/tb_mem_bus_loader.sv
// Directed bench for mem_bus_loader: write, read, bad command, timeout,
// backpressure and reset-during-access scenarios.
module tb_mem_bus_loader;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        active;

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    int unsigned mv_cycles = 0;

    mem_bus_loader #(
        .TIMEOUT  (8),
        .ACK_BYTE (8'h06),
        .NAK_BYTE (8'h15)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .active    (active)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_valid) mv_cycles <= mv_cycles + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int g;
        rx_data  = b;
        rx_valid = 1'b1;
        g = 0;
        while (!rx_ready && g < 100) begin
            tick();
            g++;
        end
        if (g == 100) check("rx_ready_wait", rx_ready, 1);
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [31:0] addr,
                              input logic has_data, input logic [31:0] data);
        send_byte(cmd);
        for (int unsigned i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
        if (has_data) begin
            for (int unsigned i = 0; i < 4; i++) send_byte(data[8*i +: 8]);
        end
    endtask

    // Called in the first mem_valid cycle; completes after `waits` stalls.
    task automatic bus_serve(input int waits, input logic [31:0] rdata,
                             input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                             input logic [3:0] exp_wstrb, input logic chk_wdata);
        check("bus_valid", mem_valid, 1);
        check("bus_addr", mem_addr, exp_addr);
        check("bus_wstrb", mem_wstrb, exp_wstrb);
        if (chk_wdata) check("bus_wdata", mem_wdata, exp_wdata);
        for (int i = 0; i < waits; i++) begin
            mem_ready = 1'b0;
            tick();
            check("bus_hold", {mem_valid, mem_wstrb, mem_addr[26:0]},
                  {1'b1, exp_wstrb, exp_addr[26:0]});
        end
        mem_ready = 1'b1;
        mem_rdata = rdata;
        tick();
        mem_ready = 1'b0;
        mem_rdata = '0;
        check("bus_release", mem_valid, 0);
        check("resp_latency", tx_valid, 1);
    endtask

    task automatic recv_byte(input logic [7:0] exp, input int stall);
        int g;
        g = 0;
        while (!tx_valid && g < 100) begin
            tick();
            g++;
        end
        if (g == 100) check("tx_valid_wait", tx_valid, 1);
        for (int i = 0; i < stall; i++) begin
            tx_ready = 1'b0;
            tick();
            check("tx_stall", {tx_valid, rx_ready, tx_data}, {1'b1, 1'b0, exp});
        end
        tx_ready = 1'b1;
        check("tx_data", tx_data, exp);
        tick();
        tx_ready = 1'b0;
    endtask

    initial begin
        int unsigned mv0;
        int cnt;

        // Reset state
        tick();
        tick();
        check("rst_mem", {mem_valid, mem_wstrb, mem_addr, mem_wdata}, '0);
        check("rst_tx", {tx_valid, tx_data}, '0);
        check("rst_active", active, 0);
        check("rst_rx_ready", rx_ready, 1);
        resetn = 1'b1;
        tick();

        // tx_ready with nothing to send has no effect
        tx_ready = 1'b1;
        tick();
        tick();
        check("idle_tx_ready", {tx_valid, active}, 0);
        tx_ready = 1'b0;

        // Write path
        send_byte(8'h57);
        check("active_addr", active, 1);
        for (int unsigned i = 0; i < 4; i++) send_byte(8'h10 >> (8 * i));
        send_byte(8'hEF);
        send_byte(8'hBE);
        send_byte(8'hAD);
        send_byte(8'hDE);
        bus_serve(0, 32'h0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b1);
        recv_byte(8'h06, 0);
        check("wr_done", {active, tx_valid}, 0);

        // Read path, 3 wait cycles, unaligned frame address
        mv0 = mv_cycles;
        send_frame(8'h52, 32'h0200_0007, 1'b0, '0);
        bus_serve(3, 32'h1234_5678, 32'h0200_0004, '0, 4'h0, 1'b0);
        check("rd_mv_cycles", mv_cycles - mv0, 4);
        recv_byte(8'h78, 0);
        recv_byte(8'h56, 0);
        recv_byte(8'h34, 0);
        recv_byte(8'h12, 0);
        check("rd_done", {active, tx_valid}, 0);

        // Bad command then a normal read
        mv0 = mv_cycles;
        send_byte(8'h41);
        check("bad_active", active, 1);
        recv_byte(8'h15, 0);
        check("bad_no_bus", mv_cycles - mv0, 0);
        check("bad_done", {active, tx_valid}, 0);
        send_frame(8'h52, 32'h0000_0004, 1'b0, '0);
        bus_serve(0, 32'hA1B2_C3D4, 32'h0000_0004, '0, 4'h0, 1'b0);
        recv_byte(8'hD4, 0);
        recv_byte(8'hC3, 0);
        recv_byte(8'hB2, 0);
        recv_byte(8'hA1, 0);

        // Timeout: no mem_ready at all
        send_frame(8'h52, 32'h0000_0100, 1'b0, '0);
        cnt = 0;
        while (mem_valid && cnt < 50) begin
            cnt++;
            tick();
        end
        check("tmo_cycles", cnt, 8);
        recv_byte(8'h15, 0);
        check("tmo_done", {active, tx_valid, mem_valid}, 0);

        // mem_ready in the cycle the timeout expires is a success
        send_frame(8'h52, 32'h0000_0008, 1'b0, '0);
        bus_serve(7, 32'hCAFE_F00D, 32'h0000_0008, '0, 4'h0, 1'b0);
        recv_byte(8'h0D, 0);
        recv_byte(8'hF0, 0);
        recv_byte(8'hFE, 0);
        recv_byte(8'hCA, 0);

        // Backpressure with a pending rx byte held through the response
        send_frame(8'h52, 32'h0000_000C, 1'b0, '0);
        bus_serve(0, 32'h1122_3344, 32'h0000_000C, '0, 4'h0, 1'b0);
        rx_data  = 8'h57;
        rx_valid = 1'b1;
        recv_byte(8'h44, 5);
        recv_byte(8'h33, 5);
        recv_byte(8'h22, 5);
        recv_byte(8'h11, 5);
        check("bp_done", {tx_valid, active, rx_ready}, 32'h1);
        send_byte(8'h57);
        check("bp_pending_taken", active, 1);
        for (int unsigned i = 0; i < 4; i++) send_byte(8'h20 >> (8 * i));
        send_byte(8'h78);
        send_byte(8'h56);
        send_byte(8'h34);
        send_byte(8'h12);
        bus_serve(0, 32'h0, 32'h0000_0020, 32'h1234_5678, 4'hF, 1'b1);
        recv_byte(8'h06, 0);

        // Reset while the bus access is outstanding
        send_frame(8'h57, 32'h0000_0040, 1'b1, 32'h0000_0001);
        check("mid_valid", mem_valid, 1);
        #2 resetn = 1'b0;
        #1;
        check("mid_rst_async", {mem_valid, tx_valid, active, mem_wstrb}, 0);
        check("mid_rst_rx_ready", rx_ready, 1);
        tick();
        resetn = 1'b1;
        tick();
        send_frame(8'h57, 32'h0000_0044, 1'b1, 32'hAA55_AA55);
        bus_serve(0, 32'h0, 32'h0000_0044, 32'hAA55_AA55, 4'hF, 1'b1);
        recv_byte(8'h06, 0);
        check("post_rst_done", {active, tx_valid}, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
